// File: rtl/led_pkg.sv
// led_pkg: constants and feeder FSM states shared by the LED feeder and controller
package led_pkg;
    localparam int LED_DATA_W      = 16;
    localparam int LED_FRAME_WORDS = 256;
    localparam int LED_WC_W        = 9;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_GAP,
        ST_WAIT,
        ST_DONE
    } feed_state_t;
endpackage

// File: rtl/led_word_fifo.sv
// led_word_fifo: synchronous FIFO with registered full/empty flags and occupancy count
module led_word_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         rd_en,
    output logic [W-1:0] rd_data,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0]   count, count_n;
    logic          do_rd, do_wr;

    // a pop frees a slot in the same cycle, so a write while full is fine then
    assign do_rd   = rd_en && !empty;
    assign do_wr   = wr_en && (!full || do_rd);
    assign count_n = count + {{AW{1'b0}}, do_wr} - {{AW{1'b0}}, do_rd};
    assign rd_data = mem[rp];

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else begin
            wp    <= do_wr ? wp + 1'b1 : wp;
            rp    <= do_rd ? rp + 1'b1 : rp;
            count <= count_n;
            full  <= count_n == (AW + 1)'(DEPTH);
            empty <= count_n == '0;
        end

    always_ff @(posedge clk)
        if (do_wr) mem[wp] <= wr_data;
endmodule

// File: rtl/led_serial_feeder.sv
// led_serial_feeder: buffers parallel grayscale words and shifts them out LSB first
// as the DAI/DEN stream, one bounded frame of FRAME_WORDS words per start.
module led_serial_feeder
    import led_pkg::*;
#(
    parameter int DATA_W      = LED_DATA_W,
    parameter int FIFO_DEPTH  = 4,
    parameter int FRAME_WORDS = LED_FRAME_WORDS,
    parameter int GAP_CYCLES  = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                s_valid,
    input  logic [DATA_W-1:0]   s_data,
    output logic                s_ready,
    output logic                dai,
    output logic                den,
    output logic                busy,
    output logic                frame_done,
    output logic                underrun,
    output logic [LED_WC_W-1:0] word_cnt
);
    localparam int BW = $clog2(DATA_W);
    localparam int GW = GAP_CYCLES > 1 ? $clog2(GAP_CYCLES) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

    feed_state_t         state, state_n;
    logic [DATA_W-1:0]   shreg, shreg_n, fifo_data;
    logic [BW-1:0]       bit_cnt, bit_n;
    logic [GW-1:0]       gap_cnt, gap_n;
    logic [LED_WC_W-1:0] wc_n;
    logic                busy_n, und_n, fd_n, den_n, dai_n, load, fifo_full, fifo_empty;

    assign s_ready = !fifo_full;

    led_word_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (s_valid && s_ready),
        .wr_data (s_data),
        .rd_en   (load),
        .rd_data (fifo_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state      <= ST_IDLE;
            shreg      <= '0;
            bit_cnt    <= '0;
            gap_cnt    <= '0;
            word_cnt   <= '0;
            busy       <= 1'b0;
            underrun   <= 1'b0;
            frame_done <= 1'b0;
            den        <= 1'b0;
            dai        <= 1'b0;
        end else begin
            state      <= state_n;
            shreg      <= shreg_n;
            bit_cnt    <= bit_n;
            gap_cnt    <= gap_n;
            word_cnt   <= wc_n;
            busy       <= busy_n;
            underrun   <= und_n;
            frame_done <= fd_n;
            den        <= den_n;
            dai        <= dai_n;
        end

    always_comb begin
        state_n = state;
        shreg_n = shreg;
        bit_n   = bit_cnt;
        gap_n   = gap_cnt;
        wc_n    = word_cnt;
        busy_n  = busy;
        und_n   = underrun;
        fd_n    = 1'b0;
        den_n   = 1'b0;
        dai_n   = 1'b0;
        load    = 1'b0;
        case (state)
            ST_IDLE:
                if (start) begin
                    state_n = ST_LOAD;
                    busy_n  = 1'b1;
                    wc_n    = '0;
                    und_n   = 1'b0;
                end
            ST_LOAD:
                if (!fifo_empty) load = 1'b1;
                else state_n = ST_WAIT;
            ST_SHIFT:
                if (bit_cnt != LAST_BIT) begin
                    den_n   = 1'b1;
                    dai_n   = shreg[0];
                    shreg_n = shreg >> 1;
                    bit_n   = bit_cnt + 1'b1;
                end else begin
                    wc_n = 32'(word_cnt) >= FRAME_WORDS ? word_cnt : word_cnt + 1'b1;
                    if (32'(word_cnt) + 1 >= FRAME_WORDS) begin
                        state_n = ST_DONE;
                        busy_n  = 1'b0;
                        fd_n    = 1'b1;
                    end else if (GAP_CYCLES > 0) begin
                        state_n = ST_GAP;
                        gap_n   = '0;
                    end else if (!fifo_empty) begin
                        load = 1'b1;
                    end else begin
                        und_n   = 1'b1;
                        state_n = ST_WAIT;
                    end
                end
            // the final gap cycle loads directly so the gap is exactly GAP_CYCLES long
            ST_GAP:
                if (32'(gap_cnt) + 1 < GAP_CYCLES) gap_n = gap_cnt + 1'b1;
                else if (!fifo_empty) load = 1'b1;
                else begin
                    und_n   = 1'b1;
                    state_n = ST_WAIT;
                end
            ST_WAIT:
                if (!fifo_empty) state_n = ST_LOAD;
            ST_DONE:
                state_n = ST_IDLE;
            default:
                state_n = ST_IDLE;
        endcase
        if (load) begin
            state_n = ST_SHIFT;
            shreg_n = fifo_data >> 1;
            bit_n   = '0;
            den_n   = 1'b1;
            dai_n   = fifo_data[0];
        end
    end
endmodule

// File: doc/led_serial_feeder.md
Name: led_serial_feeder

Overview:
- Upstream stage of the LED display controller.
- Accepts 16-bit grayscale words on a parallel valid/ready interface, buffers them in a small FIFO, and shifts them out as the DAI/DEN serial stream, LSB first.
- The downstream LED controller samples DAI/DEN on DCK, assembles 16 bits per word, and writes each completed word into its 256-entry frame buffer.
- Frames are bounded: exactly FRAME_WORDS words per start command.

Parameters:
- DATA_W, 16, bits per word; one DEN burst unit.
- FIFO_DEPTH, 4, input FIFO entries (power of two, >=2).
- FRAME_WORDS, 256, words per frame; matches the downstream frame buffer depth.
- GAP_CYCLES, 0, forced DEN-low cycles inserted between consecutive words (0 = back-to-back).

Ports:
- clk  in  1  serial clock; the same net as DCK of the downstream controller.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  single-cycle pulse; begins a frame when idle; ignored otherwise.
- s_valid  in  1  input word valid.
- s_data  in  16  input grayscale word.
- s_ready  out  1  FIFO not full.
- dai  out  1  serial data; bit 0 of the word goes out first.
- den  out  1  serial enable; high exactly while a valid bit is on dai.
- busy  out  1  frame in progress.
- frame_done  out  1  one-cycle pulse after the last bit of the last word.
- underrun  out  1  sticky; set when the FIFO is empty at a word boundary mid-frame; cleared by start.
- word_cnt  out  9  words fully sent in the current frame.

Behaviour:
- Reset values: dai=0, den=0, busy=0, frame_done=0, underrun=0, word_cnt=0, FIFO empty, s_ready=1, state=IDLE.
- All outputs are registered.
- FIFO:
  - write when s_valid && s_ready; read when the FSM loads a word.
  - Simultaneous read and write while full is allowed; occupancy is unchanged.
  - s_ready is the registered FIFO not-full flag.
  - The FIFO accepts words in every state, including IDLE, so a frame can be preloaded.
- FSM states: IDLE, LOAD, SHIFT, GAP, WAIT, DONE.
  - IDLE: den=0. On start: busy=1, word_cnt=0, underrun=0; go to LOAD.
  - LOAD:
    - If the FIFO is non-empty: pop into a 16-bit shift register, bit_cnt=0, go to SHIFT.
    - Else: go to WAIT.
  - SHIFT:
    - Each cycle: den=1, dai=shreg[0], shreg shifts right, bit_cnt increments.
    - At bit_cnt==15: word_cnt increments.
    - If word_cnt+1==FRAME_WORDS, go to DONE.
    - Else if GAP_CYCLES>0, go to GAP.
    - Else if the FIFO is non-empty, pop the next word in the same cycle and stay in SHIFT, so den remains high across the word boundary.
    - Else set underrun and go to WAIT.
  - GAP: den=0 for exactly GAP_CYCLES cycles, then go to LOAD.
  - WAIT: den=0. Go to LOAD when the FIFO is non-empty. Partial words are never emitted, because the downstream bit counter realigns whenever den is low.
  - DONE: den=0, frame_done=1 for one cycle, busy=0, go to IDLE.
- Latency: a word written into an empty FIFO while in LOAD or WAIT produces its first den=1 bit 2 cycles after the write edge.
- Back-to-back words give a continuous den-high run of 16*N cycles.
- start while busy is ignored. start in the same cycle as frame_done's DONE state is also ignored.
- word_cnt saturates at FRAME_WORDS; there is no wrap within a frame. It holds its value after frame_done until the next start.
- Reset mid-word drops den to 0 asynchronously; the partial word is discarded and the FIFO is flushed.
- Bit order is fixed: s_data[0] goes first and s_data[15] goes last, so the downstream right-shift assembly reconstructs the word unchanged.

Decomposition:
- Package led_pkg:
  - LED_DATA_W=16, LED_FRAME_WORDS=256.
  - Word-count width constant (9).
  - The feeder FSM state enum.
  - Shared with the downstream controller.
- One sub-module: led_word_fifo (synchronous, parameterised depth/width, full/empty, occupancy).

Test Plan:
- Preload 4 words 0x0001, 0x8000, 0xA5A5, 0xFFFF, then start -> den high for 64 consecutive cycles; dai sequence 1,0×15 | 0×15,1 | 1,0,1,0,0,1,0,1,1,0,1,0,0,1,0,1 | 1×16; word_cnt=4.
- FRAME_WORDS=256, continuous supply of incrementing words 0..255 -> den high for 4096 cycles; frame_done pulses once the cycle after the last bit; busy falls; word_cnt=256; downstream-model buffer holds 0..255.
- Supply stalls after word 10 for 20 cycles -> den low from the word boundary until 2 cycles after the next write; no partial word; underrun=1; frame still completes with 256 words.
- GAP_CYCLES=3 with 3 words -> each 16-cycle den burst is separated by exactly 3 den-low cycles.
- Assert rst at bit 7 of word 5 -> den=0 immediately; s_ready=1; word_cnt=0; next start sends the first newly written word from bit 0.
- FIFO full (4 entries) with s_valid held high -> s_ready=0; no word lost or duplicated; start pulse during busy is ignored and word_cnt is unaffected.
